nibble_add_scheduler: RTL and testbench

Shares one registered nibble adder (the 4-bit sum/carry datapath) between N_REQ requesters. Requests are granted round-robin over valid/ready handshakes. The block sequences each operand pair through the adder, waits out the adder latency, and returns the 5-bit result tagged with the requester ID. It sits between the pin-level input decode and the shared adder instance in the top-level tile.

---
 rtl/nibble_add_scheduler.sv | 155 +++++++++++++++
 tb/tb_nibble_add_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_add_scheduler.sv
// nibble_add_scheduler
//   Shares one registered nibble adder between N_REQ requesters. Requests are
//   granted round-robin. Each operand pair is sent to the adder, the block
//   waits out the adder latency, and the W+1-bit result is returned with the
//   index of the requester that owns it. Only one transaction is in flight.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high, clears all state
//   req_valid  : per-requester request valid
//   req_a/b    : packed operands, requester i on bits [i*W +: W]
//   req_ready  : per-requester accept (one-hot or zero), combinational in IDLE
//   rsp_valid  : result valid (high in RESP)
//   rsp_ready  : result consumer ready
//   rsp_id     : owner of the result
//   rsp_sum    : {carry, sum}
//   adder_a/b  : registered operands to the shared adder
//   adder_sum  : adder result, valid ADD_LAT edges after adder_a/adder_b change
//   busy       : high in any state other than IDLE
module nibble_add_scheduler #(
  parameter int N_REQ   = 4,
  parameter int W       = 4,
  parameter int ADD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*W-1:0]       req_a,
  input  logic [N_REQ*W-1:0]       req_b,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [W:0]               rsp_sum,
  output logic [W-1:0]             adder_a,
  output logic [W-1:0]             adder_b,
  input  logic [W:0]               adder_sum,
  output logic                     busy
);

  localparam int ID_W = $clog2(N_REQ);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0]      CNT_INIT = 2'(ADD_LAT);
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(N_REQ - 1);
  localparam logic [ID_W-1:0] ID_ONE   = ID_W'(1'b1);

  logic [1:0]      state_r;
  logic [ID_W-1:0] ptr_r;
  logic [1:0]      cnt_r;
  logic [W-1:0]    adder_a_r;
  logic [W-1:0]    adder_b_r;
  logic [ID_W-1:0] rsp_id_r;
  logic [W:0]      rsp_sum_r;

  logic            win_found_s;
  logic [ID_W-1:0] win_id_s;
  logic            accept_s;
  logic [ID_W-1:0] ptr_next_s;
  logic [W-1:0]    win_a_s;
  logic [W-1:0]    win_b_s;

  // Requester index that sits 'off' positions above 'base', wrapping at N_REQ.
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int sum_v;
    sum_v = int'(base) + off;
    if (sum_v >= N_REQ) begin
      sum_v = sum_v - N_REQ;
    end else begin
      sum_v = sum_v;
    end
    return ID_W'(sum_v);
  endfunction

  // Round-robin winner search starting at ptr_r. The scan runs from the
  // farthest offset down to offset 0 so the nearest valid requester is the
  // last one written and therefore wins.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      win_found_s = win_found_s | req_valid[wrap_idx(ptr_r, k)];
      win_id_s    = req_valid[wrap_idx(ptr_r, k)] ? wrap_idx(ptr_r, k) : win_id_s;
    end
  end

  assign accept_s   = (state_r == ST_IDLE) && win_found_s;
  assign ptr_next_s = (win_id_s == LAST_ID) ? '0 : (win_id_s + ID_ONE);
  assign win_a_s    = req_a[int'(win_id_s) * W +: W];
  assign win_b_s    = req_b[int'(win_id_s) * W +: W];

  // Grant: only the winner sees ready, and only while IDLE.
  always_comb begin
    req_ready = '0;
    if (accept_s) begin
      req_ready[win_id_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Transaction sequencer: accept in IDLE, count out the adder latency in
  // WAIT, hold the captured result in RESP until the consumer takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      ptr_r     <= '0;
      cnt_r     <= 2'd0;
      adder_a_r <= '0;
      adder_b_r <= '0;
      rsp_id_r  <= '0;
      rsp_sum_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            adder_a_r <= win_a_s;
            adder_b_r <= win_b_s;
            rsp_id_r  <= win_id_s;
            ptr_r     <= ptr_next_s;
            cnt_r     <= CNT_INIT;
            state_r   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_r != 2'd0) begin
            cnt_r <= cnt_r - 2'd1;
          end else begin
            rsp_sum_r <= adder_sum;
            state_r   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign adder_a   = adder_a_r;
  assign adder_b   = adder_b_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_sum   = rsp_sum_r;
  assign rsp_valid = (state_r == ST_RESP);
  assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_nibble_add_scheduler.sv
module tb_nibble_add_scheduler;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  // main instance: N_REQ=4, ADD_LAT=1
  logic [3:0]  m_valid, m_ready;
  logic [15:0] m_a, m_b;
  logic        m_rsp_valid, m_rsp_ready, m_busy;
  logic [1:0]  m_id;
  logic [4:0]  m_sum, m_asum;
  logic [3:0]  m_aa, m_ab;

  // sweep instance: N_REQ=2, ADD_LAT=0
  logic [1:0]  z_valid, z_ready;
  logic [7:0]  z_a, z_b;
  logic        z_rsp_valid, z_rsp_ready, z_busy;
  logic [0:0]  z_id;
  logic [4:0]  z_sum, z_asum;
  logic [3:0]  z_aa, z_ab;

  // sweep instance: N_REQ=2, ADD_LAT=3
  logic [1:0]  t_valid, t_ready;
  logic [7:0]  t_a, t_b;
  logic        t_rsp_valid, t_rsp_ready, t_busy;
  logic [0:0]  t_id;
  logic [4:0]  t_sum, t_asum, t_s1, t_s2;
  logic [3:0]  t_aa, t_ab;

  nibble_add_scheduler #(.N_REQ(4), .W(4), .ADD_LAT(1)) dut_m (
    .clk(clk), .reset(reset), .req_valid(m_valid), .req_a(m_a), .req_b(m_b),
    .req_ready(m_ready), .rsp_valid(m_rsp_valid), .rsp_ready(m_rsp_ready),
    .rsp_id(m_id), .rsp_sum(m_sum), .adder_a(m_aa), .adder_b(m_ab),
    .adder_sum(m_asum), .busy(m_busy));

  nibble_add_scheduler #(.N_REQ(2), .W(4), .ADD_LAT(0)) dut_z (
    .clk(clk), .reset(reset), .req_valid(z_valid), .req_a(z_a), .req_b(z_b),
    .req_ready(z_ready), .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_id(z_id), .rsp_sum(z_sum), .adder_a(z_aa), .adder_b(z_ab),
    .adder_sum(z_asum), .busy(z_busy));

  nibble_add_scheduler #(.N_REQ(2), .W(4), .ADD_LAT(3)) dut_t (
    .clk(clk), .reset(reset), .req_valid(t_valid), .req_a(t_a), .req_b(t_b),
    .req_ready(t_ready), .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready),
    .rsp_id(t_id), .rsp_sum(t_sum), .adder_a(t_aa), .adder_b(t_ab),
    .adder_sum(t_asum), .busy(t_busy));

  // Adder models with latencies matching each instance.
  always @(posedge clk) m_asum <= {1'b0, m_aa} + {1'b0, m_ab};
  assign z_asum = {1'b0, z_aa} + {1'b0, z_ab};
  always @(posedge clk) begin
    t_s1   <= {1'b0, t_aa} + {1'b0, t_ab};
    t_s2   <= t_s1;
    t_asum <= t_s2;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", m_busy); end
    checks++; if (m_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", m_rsp_valid); end
    checks++; if (m_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", m_ready); end
    checks++; if ({m_aa, m_ab} !== 8'h00) begin errors++; $display("FAIL reset_adder_ops: got %h expected 00", {m_aa, m_ab}); end
    checks++; if ({m_id, m_sum} !== 7'h00) begin errors++; $display("FAIL reset_rsp_regs: got %h expected 00", {m_id, m_sum}); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_single();
    m_rsp_ready = 1'b1;
    m_valid = 4'b0100; m_a = 16'h0300; m_b = 16'h0400;
    #1;
    checks++; if (m_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", m_ready); end
    checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL single_busy_c0: got %b expected 0", m_busy); end
    step();
    m_valid = 4'b0000;
    checks++; if ({m_aa, m_ab} !== 8'h34) begin errors++; $display("FAIL single_adder_ops: got %h expected 34", {m_aa, m_ab}); end
    checks++; if ({m_busy, m_rsp_valid} !== 2'b10) begin errors++; $display("FAIL single_after_e0: got %b expected 10", {m_busy, m_rsp_valid}); end
    step();
    checks++; if ({m_busy, m_rsp_valid} !== 2'b10) begin errors++; $display("FAIL single_cycle1: got %b expected 10", {m_busy, m_rsp_valid}); end
    step();
    checks++; if ({m_busy, m_rsp_valid} !== 2'b11) begin errors++; $display("FAIL single_cycle2: got %b expected 11", {m_busy, m_rsp_valid}); end
    checks++; if (m_id !== 2'd2) begin errors++; $display("FAIL single_id: got %0d expected 2", m_id); end
    checks++; if (m_sum !== 5'h07) begin errors++; $display("FAIL single_sum: got %h expected 07", m_sum); end
    step();
    checks++; if ({m_busy, m_rsp_valid} !== 2'b00) begin errors++; $display("FAIL single_done: got %b expected 00", {m_busy, m_rsp_valid}); end
  endtask

  task automatic test_carry();
    logic [3:0] ops [2];
    logic [4:0] exp_sum [2];
    ops[0] = 4'hF; exp_sum[0] = 5'h1E;
    ops[1] = 4'h8; exp_sum[1] = 5'h10;
    m_rsp_ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      m_valid = 4'b0001; m_a = {12'h000, ops[n]}; m_b = {12'h000, ops[n]};
      #1;
      checks++; if (m_ready !== 4'b0001) begin errors++; $display("FAIL carry_ready[%0d]: got %b expected 0001", n, m_ready); end
      step();
      m_valid = 4'b0000;
      for (int k = 0; k < 10 && !m_rsp_valid; k++) step();
      checks++; if (m_rsp_valid !== 1'b1) begin errors++; $display("FAIL carry_timeout[%0d]: got %b expected 1", n, m_rsp_valid); end
      checks++; if ({m_id, m_sum} !== {2'd0, exp_sum[n]}) begin errors++; $display("FAIL carry_result[%0d]: got id %0d sum %h expected id 0 sum %h", n, m_id, m_sum, exp_sum[n]); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_id;
    do_reset();
    m_rsp_ready = 1'b1;
    m_a = {4'd3, 4'd2, 4'd1, 4'd0}; m_b = {4'd3, 4'd2, 4'd1, 4'd0};
    m_valid = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp_id = 2'(t % 4);
      #1;
      checks++; if (m_ready !== (4'b0001 << exp_id)) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected one-hot %0d", t, m_ready, exp_id); end
      step();
      for (int k = 0; k < 10 && !m_rsp_valid; k++) step();
      checks++; if (m_rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_timeout[%0d]: got %b expected 1", t, m_rsp_valid); end
      checks++; if ({m_id, m_sum} !== {exp_id, 2'b00, exp_id, 1'b0}) begin errors++; $display("FAIL rr_result[%0d]: got id %0d sum %h expected id %0d sum %h", t, m_id, m_sum, exp_id, {2'b00, exp_id, 1'b0}); end
      step();
    end
    m_valid = 4'b0000;
    // Serve requester 1 alone, then 0 and 3 together: 3 must win.
    do_reset();
    m_valid = 4'b0010;
    step();
    m_valid = 4'b0000;
    for (int k = 0; k < 10 && !m_rsp_valid; k++) step();
    checks++; if (m_id !== 2'd1) begin errors++; $display("FAIL rr_serve1: got %0d expected 1", m_id); end
    step();
    m_valid = 4'b1001;
    #1;
    checks++; if (m_ready !== 4'b1000) begin errors++; $display("FAIL rr_after1: got %b expected 1000", m_ready); end
    m_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    m_rsp_ready = 1'b0;
    m_valid = 4'b0001; m_a = 16'h0005; m_b = 16'h0006;
    step();
    m_valid = 4'b0110; m_a = 16'h0000; m_b = 16'h0000;
    for (int k = 0; k < 10 && !m_rsp_valid; k++) step();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if ({m_rsp_valid, m_busy, m_id, m_sum} !== {1'b1, 1'b1, 2'd0, 5'h0B}) begin errors++; $display("FAIL bp_hold[%0d]: got v%b b%b id %0d sum %h expected v1 b1 id 0 sum 0b", c, m_rsp_valid, m_busy, m_id, m_sum); end
      checks++; if (m_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0000", c, m_ready); end
      step();
    end
    m_rsp_ready = 1'b1;
    step();
    checks++; if ({m_rsp_valid, m_busy} !== 2'b00) begin errors++; $display("FAIL bp_release: got %b expected 00", {m_rsp_valid, m_busy}); end
    #1;
    checks++; if (m_ready !== 4'b0010) begin errors++; $display("FAIL bp_next_grant: got %b expected 0010", m_ready); end
    m_valid = 4'b0000;
  endtask

  task automatic test_reset_mid();
    m_rsp_ready = 1'b1;
    m_valid = 4'b0010; m_a = 16'h0010; m_b = 16'h0020;
    step();
    m_valid = 4'b0000;
    step();
    checks++; if ({m_busy, m_rsp_valid} !== 2'b10) begin errors++; $display("FAIL mid_in_wait: got %b expected 10", {m_busy, m_rsp_valid}); end
    reset = 1'b1;
    #1;
    checks++; if ({m_busy, m_rsp_valid} !== 2'b00) begin errors++; $display("FAIL mid_async_state: got %b expected 00", {m_busy, m_rsp_valid}); end
    checks++; if ({m_aa, m_ab} !== 8'h00) begin errors++; $display("FAIL mid_async_ops: got %h expected 00", {m_aa, m_ab}); end
    step();
    reset = 1'b0;
    m_valid = 4'b1001;
    #1;
    checks++; if (m_ready !== 4'b0001) begin errors++; $display("FAIL mid_priority: got %b expected 0001", m_ready); end
    m_valid = 4'b0000;
  endtask

  task automatic test_param_sweep();
    logic exp_v;
    z_valid = 2'b10; z_a = 8'h90; z_b = 8'h90;
    #1;
    checks++; if (z_ready !== 2'b10) begin errors++; $display("FAIL lat0_ready: got %b expected 10", z_ready); end
    step();
    z_valid = 2'b00;
    checks++; if (z_rsp_valid !== 1'b0) begin errors++; $display("FAIL lat0_cycle0: got %b expected 0", z_rsp_valid); end
    step();
    checks++; if ({z_rsp_valid, z_id, z_sum} !== {1'b1, 1'b1, 5'h12}) begin errors++; $display("FAIL lat0_cycle1: got v%b id %0d sum %h expected v1 id 1 sum 12", z_rsp_valid, z_id, z_sum); end
    step();
    checks++; if (z_rsp_valid !== 1'b0) begin errors++; $display("FAIL lat0_done: got %b expected 0", z_rsp_valid); end
    z_valid = 2'b11;
    #1;
    checks++; if (z_ready !== 2'b01) begin errors++; $display("FAIL lat0_wrap: got %b expected 01", z_ready); end
    z_valid = 2'b00;

    t_valid = 2'b01; t_a = 8'h0A; t_b = 8'h07;
    #1;
    checks++; if (t_ready !== 2'b01) begin errors++; $display("FAIL lat3_ready: got %b expected 01", t_ready); end
    step();
    t_valid = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      step();
      exp_v = (k == 4);
      checks++; if (t_rsp_valid !== exp_v) begin errors++; $display("FAIL lat3_cycle%0d: got %b expected %b", k, t_rsp_valid, exp_v); end
    end
    checks++; if ({t_id, t_sum} !== {1'b0, 5'h11}) begin errors++; $display("FAIL lat3_result: got id %0d sum %h expected id 0 sum 11", t_id, t_sum); end
    step();
    t_valid = 2'b11;
    #1;
    checks++; if (t_ready !== 2'b10) begin errors++; $display("FAIL lat3_ptr: got %b expected 10", t_ready); end
    t_valid = 2'b00;
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1;
    m_valid = 4'b0000; m_a = 16'h0000; m_b = 16'h0000; m_rsp_ready = 1'b1;
    z_valid = 2'b00;   z_a = 8'h00;    z_b = 8'h00;    z_rsp_ready = 1'b1;
    t_valid = 2'b00;   t_a = 8'h00;    t_b = 8'h00;    t_rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_carry();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_param_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
